// File: rtl/core_pkg.sv
// Shared types for the execute stage: ALU codes, result-source encodings,
// forwarding selects and the control bundles carried through ID/EX and EX/MEM.
package core_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
        logic        mem_write;
        logic        jump;
        logic        branch;
        alu_ctrl_e   alu_control;
        logic        alu_src;
    } ex_ctrl_t;

    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
        logic        mem_write;
    } mem_ctrl_t;

    localparam ex_ctrl_t NOP_CTRL = '0;

endpackage

// File: rtl/alu.sv
// Combinational ALU for the execute stage; unsupported codes yield zero.
module alu
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_ctrl_e       alu_control,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    always_comb begin
        result = '0;
        case (alu_control)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ID/EX register, operand forwarding, ALU, branch/jump resolution, EX/MEM register.
// Define EXEC_PERF_CNT_EN to add the executed-instruction and redirect counters.
module execute_stage
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_e,
    input  logic            flush_e,
    input  logic            valid_d,
    input  ex_ctrl_t        ctrl_d,
    input  logic [XLEN-1:0] rd1_d,
    input  logic [XLEN-1:0] rd2_d,
    input  logic [XLEN-1:0] imm_ext_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [4:0]      rs1_d,
    input  logic [4:0]      rs2_d,
    input  logic [4:0]      rd_d,
    input  logic [1:0]      forward_a_e,
    input  logic [1:0]      forward_b_e,
    input  logic [XLEN-1:0] result_w,
    output logic [4:0]      rs1_e,
    output logic [4:0]      rs2_e,
    output logic [4:0]      rd_e,
    output logic            load_e,
    output logic            pc_src_e,
    output logic [XLEN-1:0] pc_target_e,
    output logic            valid_m,
    output mem_ctrl_t       ctrl_m,
    output logic [XLEN-1:0] alu_result_m,
    output logic [XLEN-1:0] write_data_m,
    output logic [4:0]      rd_m,
    output logic [XLEN-1:0] pc_plus4_m
`ifdef EXEC_PERF_CNT_EN
    ,
    output logic [31:0]     perf_exec_cnt,
    output logic [31:0]     perf_redirect_cnt
`endif
);

    logic            valid_e;
    ex_ctrl_t        ctrl_e;
    logic [XLEN-1:0] rd1_e, rd2_e, imm_ext_e, pc_e;
    logic [XLEN-1:0] src_a_e, fwd_b_e, src_b_e, alu_result_e;
    logic            zero_e;

    // Flush takes priority over stall so a squashed instruction never lingers.
    always_ff @(posedge clk) begin
        if (reset || flush_e) begin
            valid_e   <= 1'b0;
            ctrl_e    <= NOP_CTRL;
            rd1_e     <= '0;
            rd2_e     <= '0;
            imm_ext_e <= '0;
            pc_e      <= '0;
            rs1_e     <= '0;
            rs2_e     <= '0;
            rd_e      <= '0;
        end else if (!stall_e) begin
            valid_e   <= valid_d;
            ctrl_e    <= valid_d ? ctrl_d : NOP_CTRL;
            rd1_e     <= rd1_d;
            rd2_e     <= rd2_d;
            imm_ext_e <= imm_ext_d;
            pc_e      <= pc_d;
            rs1_e     <= rs1_d;
            rs2_e     <= rs2_d;
            rd_e      <= rd_d;
        end
    end

    always_comb begin
        src_a_e = rd1_e;
        case (fwd_sel_e'(forward_a_e))
            FWD_WB:  src_a_e = result_w;
            FWD_MEM: src_a_e = alu_result_m;
            default: src_a_e = rd1_e;
        endcase
    end

    always_comb begin
        fwd_b_e = rd2_e;
        case (fwd_sel_e'(forward_b_e))
            FWD_WB:  fwd_b_e = result_w;
            FWD_MEM: fwd_b_e = alu_result_m;
            default: fwd_b_e = rd2_e;
        endcase
    end

    assign src_b_e = ctrl_e.alu_src ? imm_ext_e : fwd_b_e;

    alu #(.XLEN(XLEN)) u_alu (
        .a           (src_a_e),
        .b           (src_b_e),
        .alu_control (ctrl_e.alu_control),
        .result      (alu_result_e),
        .zero        (zero_e)
    );

    assign pc_target_e = pc_e + imm_ext_e;
    assign pc_src_e    = valid_e & (ctrl_e.jump | (ctrl_e.branch & zero_e));
    assign load_e      = valid_e & (ctrl_e.result_src == RES_MEM);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_m      <= 1'b0;
            ctrl_m       <= '0;
            alu_result_m <= '0;
            write_data_m <= '0;
            rd_m         <= '0;
            pc_plus4_m   <= '0;
        end else begin
            valid_m      <= valid_e;
            ctrl_m       <= valid_e ? mem_ctrl_t'({ctrl_e.reg_write, ctrl_e.result_src, ctrl_e.mem_write})
                                    : mem_ctrl_t'('0);
            alu_result_m <= alu_result_e;
            write_data_m <= fwd_b_e;
            rd_m         <= rd_e;
            pc_plus4_m   <= pc_e + XLEN'(4);
        end
    end

`ifdef EXEC_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_exec_cnt     <= '0;
            perf_redirect_cnt <= '0;
        end else begin
            if (valid_e && !stall_e) perf_exec_cnt <= perf_exec_cnt + 32'd1;
            if (pc_src_e)            perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
        end
    end
`endif

endmodule
